// File: rtl/reconstruct4_mb_seq.sv
// Macroblock sequencer for the 4x4 luma reconstruct datapath: walks the 16 sub-blocks
// in raster order, fetches prediction, launches the datapath and scatters its results.
module reconstruct4_mb_seq #(
    parameter int BLOCK_SIZE = 4,
    parameter int MB_SIZE    = 16
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  start,
    input  logic [8*MB_SIZE*MB_SIZE-1:0]          mb_src,
    output logic                                  pred_req,
    output logic [3:0]                            pred_idx,
    input  logic                                  pred_valid,
    input  logic [8*BLOCK_SIZE*BLOCK_SIZE-1:0]    pred_data,
    output logic                                  blk_start,
    output logic [8*BLOCK_SIZE*BLOCK_SIZE-1:0]    blk_ysrc,
    output logic [8*BLOCK_SIZE*BLOCK_SIZE-1:0]    blk_ypred,
    input  logic                                  blk_done,
    input  logic [8*BLOCK_SIZE*BLOCK_SIZE-1:0]    blk_yout,
    input  logic [16*BLOCK_SIZE*BLOCK_SIZE-1:0]   blk_levels,
    input  logic                                  blk_nz,
    output logic [8*MB_SIZE*MB_SIZE-1:0]          mb_yout,
    output logic [16*MB_SIZE*MB_SIZE-1:0]         mb_levels,
    output logic [(MB_SIZE/BLOCK_SIZE)*(MB_SIZE/BLOCK_SIZE)-1:0] nz_mask,
    output logic                                  blk_wr,
    output logic [3:0]                            wr_idx,
    output logic                                  busy,
    output logic                                  done
);

    localparam int NB   = MB_SIZE / BLOCK_SIZE;
    localparam int NBLK = NB * NB;
    localparam int LVLB = 16 * BLOCK_SIZE * BLOCK_SIZE;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRED,
        S_RUN,
        S_WAIT,
        S_STORE,
        S_FIN
    } state_t;

    state_t state_q, state_d;
    logic [3:0] n_q, n_d;
    logic capture_pred, capture_blk, clear_nz;

    logic [8*BLOCK_SIZE*BLOCK_SIZE-1:0] ypred_q;
    logic [8*MB_SIZE*MB_SIZE-1:0]       yout_q;
    logic [16*MB_SIZE*MB_SIZE-1:0]      levels_q;
    logic [NBLK-1:0]                    nz_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            n_q     <= '0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        n_d          = n_q;
        pred_req     = 1'b0;
        blk_start    = 1'b0;
        blk_wr       = 1'b0;
        done         = 1'b0;
        capture_pred = 1'b0;
        capture_blk  = 1'b0;
        clear_nz     = 1'b0;
        busy         = (state_q != S_IDLE);
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    n_d      = '0;
                    clear_nz = 1'b1;
                    state_d  = S_PRED;
                end
            end
            S_PRED: begin
                pred_req = 1'b1;
                if (pred_valid) begin
                    capture_pred = 1'b1;
                    state_d      = S_RUN;
                end
            end
            S_RUN: begin
                blk_start = 1'b1;
                state_d   = S_WAIT;
            end
            S_WAIT: begin
                if (blk_done) begin
                    capture_blk = 1'b1;
                    state_d     = S_STORE;
                end
            end
            S_STORE: begin
                blk_wr = 1'b1;
                if (n_q == 4'(NBLK - 1)) begin
                    state_d = S_FIN;
                end else begin
                    n_d     = n_q + 4'd1;
                    state_d = S_PRED;
                end
            end
            S_FIN: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Source extract is forced to zero in IDLE so reset leaves every output at 0.
    always_comb begin
        blk_ysrc = '0;
        for (int unsigned b = 0; b < NBLK; b++) begin
            if (state_q != S_IDLE && n_q == 4'(b)) begin
                for (int unsigned i = 0; i < BLOCK_SIZE; i++) begin
                    for (int unsigned j = 0; j < BLOCK_SIZE; j++) begin
                        blk_ysrc[8*(BLOCK_SIZE*i+j) +: 8] =
                            mb_src[8*(MB_SIZE*(BLOCK_SIZE*(b/NB)+i) + BLOCK_SIZE*(b%NB) + j) +: 8];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ypred_q  <= '0;
            yout_q   <= '0;
            levels_q <= '0;
            nz_q     <= '0;
        end else begin
            if (capture_pred) begin
                ypred_q <= pred_data;
            end
            if (clear_nz) begin
                nz_q <= '0;
            end
            // Scatter loops over every block with a constant-index compare instead of a variable slice.
            if (capture_blk) begin
                for (int unsigned b = 0; b < NBLK; b++) begin
                    if (n_q == 4'(b)) begin
                        for (int unsigned i = 0; i < BLOCK_SIZE; i++) begin
                            for (int unsigned j = 0; j < BLOCK_SIZE; j++) begin
                                yout_q[8*(MB_SIZE*(BLOCK_SIZE*(b/NB)+i) + BLOCK_SIZE*(b%NB) + j) +: 8] <=
                                    blk_yout[8*(BLOCK_SIZE*i+j) +: 8];
                            end
                        end
                        levels_q[LVLB*b +: LVLB] <= blk_levels;
                        nz_q[b]                  <= blk_nz;
                    end
                end
            end
        end
    end

    assign pred_idx  = n_q;
    assign wr_idx    = n_q;
    assign blk_ypred = ypred_q;
    assign mb_yout   = yout_q;
    assign mb_levels = levels_q;
    assign nz_mask   = nz_q;

endmodule

// File: tb/tb_reconstruct4_mb_seq.sv
// Bench for reconstruct4_mb_seq: predictor/datapath responders, a per-cycle scoreboard
// model of the macroblock walk, and directed scenarios with hand-computed expectations.
module tb_reconstruct4_mb_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst, start, pred_valid, blk_done, blk_nz;
    logic [2047:0]   mb_src;
    logic [127:0]    pred_data, blk_yout;
    logic [255:0]    blk_levels;
    logic            pred_req, blk_start, blk_wr, busy, done;
    logic [3:0]      pred_idx, wr_idx;
    logic [127:0]    blk_ysrc, blk_ypred;
    logic [2047:0]   mb_yout;
    logic [4095:0]   mb_levels;
    logic [15:0]     nz_mask;

    reconstruct4_mb_seq #(.BLOCK_SIZE(4), .MB_SIZE(16)) dut (
        .clk(clk), .rst(rst), .start(start), .mb_src(mb_src),
        .pred_req(pred_req), .pred_idx(pred_idx), .pred_valid(pred_valid), .pred_data(pred_data),
        .blk_start(blk_start), .blk_ysrc(blk_ysrc), .blk_ypred(blk_ypred),
        .blk_done(blk_done), .blk_yout(blk_yout), .blk_levels(blk_levels), .blk_nz(blk_nz),
        .mb_yout(mb_yout), .mb_levels(mb_levels), .nz_mask(nz_mask),
        .blk_wr(blk_wr), .wr_idx(wr_idx), .busy(busy), .done(done)
    );

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [255:0] a, input logic [255:0] e);
        n_chk++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, a, e, cyc);
        end
    endtask

    function automatic logic [7:0] pix(input logic [2047:0] mb, input int y, input int x);
        return mb[8*(16*y+x) +: 8];
    endfunction

    // Sub-block n of an MB image: pixel (i,j) = image pixel (4*by+i, 4*bx+j).
    function automatic logic [127:0] src_blk(input logic [2047:0] mb, input int n);
        logic [127:0] r;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                r[8*(4*i+j) +: 8] = pix(mb, 4*(n/4)+i, 4*(n%4)+j);
        return r;
    endfunction

    function automatic logic [127:0] pred_pat(input int n);
        logic [127:0] r;
        for (int k = 0; k < 16; k++) r[8*k +: 8] = 8'(n*16 + k) ^ 8'h5A;
        return r;
    endfunction

    function automatic logic [255:0] lev_pat(input int n);
        logic [255:0] r;
        for (int k = 0; k < 16; k++) r[16*k +: 16] = 16'h0100 + 16'(n);
        return r;
    endfunction

    // Stimulus controls read by the responders.
    int L = 1;
    int stall_blk = 99;
    int stall_len = 0;
    bit spur_pv = 0;
    bit spur_bd = 0;

    // Predictor and datapath responders, driven just after each rising edge.
    initial begin
        bit pend;
        int cnt, waited;
        logic [127:0] cap_y;
        logic [3:0] dp_n;
        pend = 0; cnt = 0; waited = 0; cap_y = '0; dp_n = '0;
        pred_valid = 0; pred_data = '0; blk_done = 0; blk_yout = '0; blk_levels = '0; blk_nz = 0;
        forever begin
            @(posedge clk); #1;
            pred_valid = 0; pred_data = '0;
            blk_done = 0; blk_yout = '0; blk_levels = '0; blk_nz = 0;
            if (pend) begin
                cnt--;
                if (cnt == 0) begin
                    blk_done = 1; blk_yout = cap_y; blk_levels = lev_pat(int'(dp_n));
                    blk_nz = dp_n[0]; pend = 0;
                end
            end
            if (blk_start) begin
                pend = 1; cnt = L; cap_y = blk_ysrc;
            end
            if (spur_bd && !blk_done && (!busy || pred_req || blk_start)) begin
                blk_done = 1; blk_yout = '1; blk_levels = '1; blk_nz = 1;
            end
            if (pred_req) begin
                if (int'(pred_idx) == stall_blk && waited < stall_len) begin
                    waited++;
                end else begin
                    pred_valid = 1; pred_data = pred_pat(int'(pred_idx)); dp_n = pred_idx;
                end
            end else begin
                waited = 0;
                if (spur_pv) begin
                    pred_valid = 1; pred_data = {4{32'hDEADBEEF}};
                end
            end
        end
    end

    // Scoreboard model: tracks the accepted macroblock and block count and checks every cycle.
    bit check_en = 0;
    bit model_active = 0;
    int start_cyc = 0;
    int blk_cnt = 0;
    int exp_lat = 65;

    always @(negedge clk) begin
        bit accept;
        if (!check_en) begin
            model_active = 0;
        end else begin
            accept = start && !model_active;
            if (model_active) begin
                chk("busy_active", busy, 1'b1);
                chk("done_timing", done, cyc == start_cyc + exp_lat);
                if (cyc == start_cyc + 1) chk("nz_cleared", nz_mask, 16'h0);
                if (pred_req) begin
                    chk("pred_idx", pred_idx, blk_cnt);
                    chk("ysrc_pred", blk_ysrc, src_blk(mb_src, blk_cnt));
                end
                if (blk_start) begin
                    chk("ypred", blk_ypred, pred_pat(blk_cnt));
                    chk("ysrc_run", blk_ysrc, src_blk(mb_src, blk_cnt));
                end
                if (blk_wr) begin
                    chk("wr_idx", wr_idx, blk_cnt);
                    chk("yout_blk", src_blk(mb_yout, blk_cnt), src_blk(mb_src, blk_cnt));
                    chk("levels_slot", mb_levels[256*blk_cnt +: 256], lev_pat(blk_cnt));
                    chk("nz_partial", nz_mask, 16'hAAAA & 16'((32'd2 << blk_cnt) - 32'd1));
                    blk_cnt++;
                end
                if (done) begin
                    chk("blk_count", blk_cnt, 16);
                    model_active = 0;
                end
            end else begin
                chk("busy_idle", busy, 1'b0);
                chk("wr_idle", blk_wr, 1'b0);
                chk("done_idle", done, 1'b0);
            end
            if (accept) begin
                model_active = 1; start_cyc = cyc; blk_cnt = 0;
            end
        end
    end

    task automatic tick;
        @(posedge clk); #2;
    endtask

    task automatic set_mb(input bit patch);
        for (int y = 0; y < 16; y++)
            for (int x = 0; x < 16; x++)
                mb_src[8*(16*y+x) +: 8] = (patch && y >= 4 && y < 8 && x >= 4 && x < 8) ?
                                          8'hA5 : 8'(16*y + x);
    endtask

    // Runs one macroblock from the current cycle; optional extra starts and block-5 literal check.
    task automatic run_mb(input int lat, input bit pulse3, input bit pulse_fin, input bit a5, input int exp7);
        int t0, nwr, n7;
        bit got, p3;
        exp_lat = lat; t0 = cyc; nwr = 0; n7 = 0; got = 0; p3 = 0;
        start = 1;
        tick();
        start = 0;
        for (int k = 0; k < 400 && !got; k++) begin
            if (blk_wr) nwr++;
            if (pred_req && pred_idx == 4'd7) n7++;
            if (a5 && pred_req && pred_idx == 4'd5) chk("ysrc_a5", blk_ysrc, {16{8'hA5}});
            if (pulse3 && !p3 && pred_req && pred_idx == 4'd3) begin start = 1; p3 = 1; end
            if (done) begin
                got = 1;
                chk("done_cycle", cyc - t0, lat);
                if (pulse_fin) start = 1;
            end
            tick();
            start = 0;
        end
        chk("done_seen", got, 1'b1);
        chk("wr_pulses", nwr, 16);
        chk("pred7_cycles", n7, exp7);
        chk("nz_final", nz_mask, 16'hAAAA);
        for (int b = 0; b < 16; b++) chk("mb_yout_final", src_blk(mb_yout, b), src_blk(mb_src, b));
    endtask

    initial begin
        int found;
        rst = 1; start = 0;
        set_mb(0);
        repeat (3) tick();
        rst = 0;
        chk("rst_busy", busy, 1'b0);
        chk("rst_pred_req", pred_req, 1'b0);
        chk("rst_ysrc", blk_ysrc, 128'h0);
        chk("rst_ypred", blk_ypred, 128'h0);
        chk("rst_mb_yout", |mb_yout, 1'b0);
        chk("rst_nz", nz_mask, 16'h0);
        check_en = 1;

        // Spurious datapath done while idle, then the baseline ramp macroblock.
        spur_bd = 1;
        repeat (3) tick();
        spur_bd = 0;
        spur_pv = 1;
        run_mb(65, 0, 0, 0, 1);
        spur_pv = 0;
        chk("lit_blk0", src_blk(mb_yout, 0), 128'h33323130_23222120_13121110_03020100);
        chk("lit_blk15", src_blk(mb_yout, 15), 128'hFFFEFDFC_EFEEEDEC_DFDEDDDC_CFCECDCC);
        chk("lit_lev0", mb_levels[255:0], {16{16'h0100}});
        chk("lit_lev15", mb_levels[4095:3840], {16{16'h010F}});
        repeat (2) tick();

        // Predictor stall on block 7, spurious done in PRED/RUN, ignored starts.
        stall_blk = 7; stall_len = 5; spur_bd = 1;
        run_mb(70, 1, 1, 0, 6);
        stall_blk = 99; stall_len = 0; spur_bd = 0;

        // Start on the first IDLE cycle after done, with the A5 patch on block 5.
        set_mb(1);
        run_mb(65, 0, 0, 1, 1);
        chk("lit_blk5_a5", src_blk(mb_yout, 5), {16{8'hA5}});
        chk("lit_lev5", mb_levels[1535:1280], {16{16'h0105}});
        spur_bd = 1;
        repeat (4) tick();
        spur_bd = 0;
        chk("idle_hold_blk5", src_blk(mb_yout, 5), {16{8'hA5}});

        // Reset in WAIT of block 9 with a slow datapath; the late done must be ignored.
        L = 6; exp_lat = 16 * 9 + 1;
        start = 1;
        tick();
        start = 0;
        found = 0;
        for (int k = 0; k < 400 && found == 0; k++) begin
            if (blk_start && pred_idx == 4'd9) found = 1;
            tick();
        end
        chk("reach_blk9", found, 1);
        check_en = 0;
        rst = 1;
        tick();
        rst = 0;
        chk("rst2_busy", busy, 1'b0);
        chk("rst2_mb_yout", |mb_yout, 1'b0);
        chk("rst2_levels", |mb_levels, 1'b0);
        chk("rst2_nz", nz_mask, 16'h0);
        chk("rst2_ypred", blk_ypred, 128'h0);
        chk("rst2_pred_idx", pred_idx, 4'h0);
        for (int k = 0; k < 8; k++) begin
            chk("late_done_busy", busy, 1'b0);
            chk("late_done_wr", blk_wr, 1'b0);
            chk("late_done_yout", |mb_yout, 1'b0);
            tick();
        end
        check_en = 1;
        L = 1;
        set_mb(0);
        run_mb(65, 0, 0, 0, 1);

        repeat (2) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d checks %0d failures", n_chk, n_fail);
        $fatal(1, "watchdog");
    end

endmodule
